// File: rtl/f2sdram_burst_writer.sv
// Streams words into a FIFO and writes them out as Avalon-MM bursts toward the f2sdram port.
// Optional stall statistics output is enabled by defining F2SDRAM_WRITER_STATS_EN.
module f2sdram_burst_writer #(
    parameter int ADDRESS_WIDTH    = 29,
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 8,
    parameter int BURST_LEN        = 16,
    parameter int FIFO_DEPTH       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDRESS_WIDTH-1:0]    base_addr,
    input  logic [23:0]                 word_count,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic                        busy,
    output logic                        done,
    input  logic                        waitrequest,
    output logic [BURSTCOUNT_WIDTH-1:0] burstcount,
    output logic [ADDRESS_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]       writedata,
    output logic [DATA_WIDTH/8-1:0]     byteenable,
    output logic                        write
`ifdef F2SDRAM_WRITER_STATS_EN
    ,
    output logic [31:0]                 stall_cycles
`endif
);

    // state     | meaning
    // IDLE      | waiting for start
    // WAIT_DATA | waiting until the FIFO holds the next burst
    // BURST     | write held high until the last beat is accepted
    // DONE      | one-cycle completion pulse

    localparam int                      PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]          FIFO_FULL   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]          PTR_ONE     = (PTR_W+1)'(1);
    localparam logic [23:0]             BURST_LEN_W = 24'(BURST_LEN);
    localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE  = BURSTCOUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]      addr_q, addr_d;
    logic [23:0]                   remaining_q, remaining_d;
    logic [23:0]                   count_q, count_d;
    logic [23:0]                   accepted_q, accepted_d;
    logic [BURSTCOUNT_WIDTH-1:0]   burst_len_q, burst_len_d;
    logic [BURSTCOUNT_WIDTH-1:0]   beats_left_q, beats_left_d;

    logic                          rst_meta_q, rst_ok_q;
    logic [DATA_WIDTH-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]                wr_ptr_q, rd_ptr_q, level;
    logic                          push, pop;
    logic                          start_ok;
    logic [23:0]                   need;

    // FSM stays parked in IDLE until reset release has passed two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_ok_q   <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_ok_q   <= rst_meta_q;
        end
    end

    assign level = wr_ptr_q - rd_ptr_q;
    assign push  = data_valid && data_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    assign start_ok = (state_q == IDLE) && start && rst_ok_q;
    assign need     = (remaining_q < BURST_LEN_W) ? remaining_q : BURST_LEN_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            count_q      <= '0;
            accepted_q   <= '0;
            burst_len_q  <= BC_ONE;
            beats_left_q <= BC_ONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            count_q      <= count_d;
            accepted_q   <= accepted_d;
            burst_len_q  <= burst_len_d;
            beats_left_q <= beats_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        count_d      = count_q;
        accepted_d   = accepted_q;
        burst_len_d  = burst_len_q;
        beats_left_d = beats_left_q;
        pop          = 1'b0;

        if (push) accepted_d = accepted_q + 24'd1;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    count_d     = word_count;
                    accepted_d  = '0;
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    state_d     = (word_count == 24'd0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (24'(level) >= need) begin
                    burst_len_d  = BURSTCOUNT_WIDTH'(need);
                    beats_left_d = BURSTCOUNT_WIDTH'(need);
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (!waitrequest) begin
                    pop          = 1'b1;
                    beats_left_d = beats_left_q - BC_ONE;
                    if (beats_left_q == BC_ONE) begin
                        addr_d      = addr_q + ADDRESS_WIDTH'(burst_len_q);
                        remaining_d = remaining_q - 24'(burst_len_q);
                        state_d     = (remaining_q == 24'(burst_len_q)) ? DONE : WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign write      = (state_q == BURST);
    assign data_ready = busy && (level != FIFO_FULL) && (accepted_q < count_q);
    assign burstcount = burst_len_q;
    assign address    = addr_q;
    assign writedata  = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign byteenable = '1;

`ifdef F2SDRAM_WRITER_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (write && waitrequest && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_f2sdram_burst_writer.sv
// Randomised scoreboard bench for f2sdram_burst_writer; expected beats are derived from job
// parameters at issue time and checked by a negedge monitor.
module tb_f2sdram_burst_writer;

    localparam int AW = 29;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int BL = 16;
    localparam int FD = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [23:0]   word_count = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [DW-1:0] data = '0;
    logic          busy, done;
    logic          waitrequest = 1'b0;
    logic [BW-1:0] burstcount;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW/8-1:0] byteenable;
    logic          write;
`ifdef F2SDRAM_WRITER_STATS_EN
    logic [31:0]   stall_cycles;
`endif

    f2sdram_burst_writer #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW),
        .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .data_valid(data_valid), .data_ready(data_ready),
        .data(data), .busy(busy), .done(done), .waitrequest(waitrequest),
        .burstcount(burstcount), .address(address), .writedata(writedata),
        .byteenable(byteenable), .write(write)
`ifdef F2SDRAM_WRITER_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [DW-1:0] d;
        bit            last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] src_q[$];

    int checks = 0, passes = 0;
    int level_m = 0, max_level = 0, acc_m = 0, job_cnt = 0;
    int done_cnt = 0, beats_job = 0, write_cycles = 0, stall_m = 0;
    int vmode = 0, wmode = 0, cyc = 0;
    bit job_active = 0, in_burst = 0, acc_pend = 0, prev_done = 0;
    bit push_m, pop_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: samples mid-cycle, values seen here are what the next posedge captures
    always @(negedge clk) begin
        if (rst_n) begin
            push_m = data_valid && data_ready;
            pop_m  = write && !waitrequest;
            check("data_ready", data_ready, (job_active && level_m < FD && acc_m < job_cnt));
            if (write) begin
                write_cycles++;
                if (waitrequest) stall_m++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", write, 1'b0);
                end else begin
                    if (!in_burst) check("burst_start_level", (level_m >= int'(exp_q[0].bc)), 1'b1);
                    check("address", address, exp_q[0].addr);
                    check("burstcount", burstcount, exp_q[0].bc);
                    if (!waitrequest) begin
                        check("writedata", writedata, exp_q[0].d);
                        check("byteenable", byteenable, {(DW/8){1'b1}});
                        in_burst = !exp_q[0].last;
                        void'(exp_q.pop_front());
                        beats_job++;
                    end else begin
                        in_burst = 1;
                    end
                end
            end else if (in_burst) begin
                check("write_held", write, 1'b1);
            end
            if (prev_done) begin
                check("done_one_cycle", done, 1'b0);
                check("busy_after_done", busy, 1'b0);
            end
            if (done) begin
                done_cnt++;
                check("beats_complete_at_done", exp_q.size(), 0);
                job_active = 0;
                in_burst = 0;
`ifdef F2SDRAM_WRITER_STATS_EN
                check("stall_cycles", stall_cycles, stall_m);
`endif
            end
            prev_done = done;
            level_m = level_m + int'(push_m) - int'(pop_m);
            if (level_m > max_level) max_level = level_m;
            if (push_m) acc_m++;
            acc_pend = push_m;
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (acc_pend) void'(src_q.pop_front());
        data_valid = (src_q.size() > 0) && !(vmode == 1 && (cyc % 3) == 2);
        data = (src_q.size() > 0) ? src_q[0] : '0;
        case (wmode)
            0:       waitrequest = 1'b0;
            1:       waitrequest = ($urandom_range(0, 1) == 1);
            default: waitrequest = ($urandom_range(0, 9) < 9);
        endcase
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_write"}, write, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_data_ready"}, data_ready, 1'b0);
        check({tag, "_burstcount"}, burstcount, 1);
        check({tag, "_address"}, address, 0);
`ifdef F2SDRAM_WRITER_STATS_EN
        check({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
    endtask

    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        reset_values("rst_mid");
        exp_q.delete();
        src_q.delete();
        in_burst = 0; job_active = 0; level_m = 0; acc_pend = 0; acc_m = 0;
        job_cnt = 0; prev_done = 0; data_valid = 1'b0; start = 1'b0; waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) drive_cycle();
        check("busy_after_rst", busy, 1'b0);
        check("write_after_rst", write, 1'b0);
    endtask

    task automatic run_job(input logic [AW-1:0] b, input int n, input int vm, input int wm,
                           input bit poke, input bit rst7);
        beat_t         e;
        logic [DW-1:0] w;
        int            k, len, d0, w0;
        vmode = vm;
        wmode = wm;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            src_q.push_back(w);
            k = i / BL;
            len = (n - k * BL < BL) ? (n - k * BL) : BL;
            e.addr = b + AW'(k * BL);
            e.bc   = BW'(len);
            e.d    = w;
            e.last = (i == k * BL + len - 1);
            exp_q.push_back(e);
        end
        job_cnt = n; acc_m = 0; stall_m = 0; max_level = 0; beats_job = 0;
        d0 = done_cnt;
        w0 = write_cycles;
        drive_cycle();
        start = 1'b1;
        base_addr = b;
        word_count = 24'(n);
        drive_cycle();
        start = 1'b0;
        job_active = 1;
        for (int t = 0; t < 3000 && done_cnt == d0; t++) begin
            drive_cycle();
            if (poke && t == 4) begin
                start = 1'b1;
                base_addr = '1;
                word_count = 24'd5;
            end else begin
                start = 1'b0;
            end
            if (rst7 && beats_job == 6 && write) begin
                reset_mid();
                return;
            end
        end
        check("done_seen", done_cnt - d0, 1);
        drive_cycle();
        drive_cycle();
        check("exp_drained", exp_q.size(), 0);
        check("src_drained", src_q.size(), 0);
        if (n == 0) check("zero_job_no_write", write_cycles - w0, 0);
        if (vm == 1 && wm == 2) check("fifo_filled", max_level, FD);
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        #1;
        reset_values("rst_init");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) drive_cycle();

        run_job(29'h100, 32, 0, 0, 0, 0);
        run_job(AW'($urandom), 20, 0, 0, 1, 0);
        run_job(AW'($urandom), 16, 0, 1, 0, 0);
        run_job(AW'($urandom), 48, 1, 2, 0, 0);
        run_job(AW'($urandom), 0, 0, 0, 0, 0);
        run_job(AW'($urandom), 40, 0, 0, 0, 1);
        run_job(AW'($urandom), 20, 0, 0, 0, 0);
        run_job(29'h1FFF_FFF8, 24, 0, 1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            run_job(AW'($urandom), $urandom_range(1, 50), $urandom_range(0, 1),
                    $urandom_range(0, 2), 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/f2sdram_burst_writer.md
F2SDRAM_BURST_WRITER -- requirements
Module: f2sdram_burst_writer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 29, Avalon word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data word width.
REQ-003 SHALL have parameter BURSTCOUNT_WIDTH, default 8, burstcount width.
REQ-004 SHALL have parameter BURST_LEN, default 16, maximum words per burst (1..2^(BURSTCOUNT_WIDTH-1)).
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, input buffer depth in words (power of 2, >= BURST_LEN).
REQ-006 SHALL have ports: clk in 1, single clock for all logic.
REQ-007 SHALL have ports: rst_n in 1, reset; one clock, reset is asynchronous and active-low.
REQ-008 SHALL have ports: start in 1, one-cycle job request, honoured only when busy=0.
REQ-009 SHALL have ports: base_addr in ADDRESS_WIDTH, job start word address, sampled on start.
REQ-010 SHALL have ports: word_count in 24, job length in words, sampled on start; 0 = no-op job.
REQ-011 SHALL have ports: data_valid in 1, data_ready out 1, data in DATA_WIDTH, input stream handshake.
REQ-012 SHALL have ports: busy out 1, job active; done out 1, one-cycle pulse at job completion.
REQ-013 SHALL have ports: waitrequest in 1, burstcount out BURSTCOUNT_WIDTH, address out ADDRESS_WIDTH, writedata out DATA_WIDTH, byteenable out DATA_WIDTH/8, write out 1, Avalon-MM write master toward the f2sdram terminator.

Function
REQ-014 SHALL transfer a stream word into the FIFO on every cycle with data_valid=1 and data_ready=1.
REQ-015 SHALL drive data_ready=1 iff busy=1, the FIFO is not full, and accepted-word count < word_count.
REQ-016 SHALL implement states IDLE, WAIT_DATA, BURST, DONE.
REQ-017 IDLE: start with word_count>0 -> latch base_addr and word_count, busy=1, go to WAIT_DATA; start with word_count=0 -> go to DONE.
REQ-018 WAIT_DATA: when FIFO level >= min(BURST_LEN, remaining), latch burst length as that minimum, go to BURST on the next cycle.
REQ-019 BURST: SHALL hold write=1 continuously from first to last beat; write SHALL never be deasserted mid-burst.
REQ-020 BURST: address and burstcount SHALL be constant throughout the burst; byteenable SHALL be all ones.
REQ-021 A beat completes on any cycle with write=1 and waitrequest=0; FIFO pops on that cycle; writedata SHALL be the FIFO head (first-word-fall-through).
REQ-022 After the last beat: address += burst length (modulo 2^ADDRESS_WIDTH); remaining -= burst length; go to WAIT_DATA if remaining>0, else DONE.
REQ-023 DONE: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave the FIFO level unchanged; level SHALL never exceed FIFO_DEPTH or underflow.
REQ-026 Final burst SHALL be partial (remaining < BURST_LEN) when word_count is not a multiple of BURST_LEN.

Reset
REQ-027 On rst_n=0, state SHALL be IDLE with FIFO empty, busy=0, done=0, write=0, data_ready=0, burstcount=1, address=0, immediately and asynchronously.
REQ-028 Reset deassertion SHALL be synchronised internally; first FSM activity SHALL occur no earlier than the second clk edge after rst_n rises.
REQ-029 Reset mid-burst SHALL abort locally; downstream completion is the terminator's responsibility.

Configuration
REQ-030 With F2SDRAM_WRITER_STATS_EN defined, SHALL add output stall_cycles (32 bits), counting cycles with write=1 and waitrequest=1, cleared on accepted start, saturating at all ones.
REQ-031 Without F2SDRAM_WRITER_STATS_EN, the port and counter SHALL be absent.

Verification
REQ-032 start base_addr=0x100, word_count=32, continuous data, waitrequest=0 -> two 16-beat bursts at 0x100 and 0x110, one done pulse.
REQ-033 word_count=20 -> bursts of 16 then 4, at base and base+16.
REQ-034 waitrequest random 50% during a burst -> write stays high, all 16 words are written in order, none are dropped or duplicated.
REQ-035 data_valid gaps every 3rd cycle -> no burst starts until 16 words are buffered, and data_ready drops when the FIFO is full.
REQ-036 rst_n low mid-burst, beat 7 -> write=0 asynchronously; after release, busy=0 and a new start executes correctly.
REQ-037 word_count=0 -> done pulse, no write asserted; with STATS_EN, stall_cycles matches the waitrequest-high count in REQ-034.
